// File: rtl/pkt_rr_if.sv
// Avalon-ST packet bus bundle for pkt_rr_arbiter: NUM_PORTS flattened input
// streams and one merged output stream.
interface pkt_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int DWIDTH    = 512,
    parameter int EWIDTH    = 6
);
    localparam int PW = $clog2(NUM_PORTS);

    logic [NUM_PORTS*DWIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS-1:0]        in_sop;
    logic [NUM_PORTS-1:0]        in_eop;
    logic [NUM_PORTS*EWIDTH-1:0] in_empty;
    logic [NUM_PORTS-1:0]        in_ready;
    logic [DWIDTH-1:0]           out_data;
    logic                        out_valid;
    logic                        out_sop;
    logic                        out_eop;
    logic [EWIDTH-1:0]           out_empty;
    logic [PW-1:0]               out_port;
    logic                        out_ready;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty, out_port
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty, out_port
    );
endinterface

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS Avalon-ST streams with one
// registered output stage. Define PKT_ARB_STATS_EN to build pkt_cnt/drop_cnt.
module pkt_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DWIDTH    = 512,
    parameter int EWIDTH    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    pkt_rr_if.slave                bus,
    output logic [NUM_PORTS*32-1:0] pkt_cnt,
    output logic [15:0]            drop_cnt
);
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t               r_state;
    logic [PW-1:0]        r_grant;
    logic [PW-1:0]        r_rr_ptr;
    logic                 r_out_valid;
    logic                 r_out_sop;
    logic                 r_out_eop;
    logic [DWIDTH-1:0]    r_out_data;
    logic [EWIDTH-1:0]    r_out_empty;
    logic [PW-1:0]        r_out_port;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_drop;
    logic [PW-1:0]        w_pick;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_next_ptr;
    logic                 w_out_free;
    logic                 w_acc;
    logic                 w_acc_eop;

    assign w_req      = bus.in_valid & bus.in_sop;
    assign w_drop     = (r_state == S_IDLE) ? (bus.in_valid & ~bus.in_sop) : '0;
    assign w_out_free = ~r_out_valid | bus.out_ready;
    assign w_acc      = (r_state == S_LOCKED) & bus.in_valid[r_grant] & w_out_free;
    assign w_acc_eop  = w_acc & bus.in_eop[r_grant];
    assign w_next_ptr = (r_grant == PW'(NUM_PORTS - 1)) ? '0 : r_grant + PW'(1);

    // Scan from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        w_pick = r_rr_ptr;
        w_sum  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_PORTS))
                w_sum = w_sum - (PW+1)'(NUM_PORTS);
            if (w_req[w_sum[PW-1:0]])
                w_pick = w_sum[PW-1:0];
        end
    end

    always_comb begin
        bus.in_ready = w_drop;
        if (r_state == S_LOCKED)
            bus.in_ready[r_grant] = w_out_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= '0;
            r_out_empty <= '0;
            r_out_port  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_pick;
                        r_state <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (w_acc_eop) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_sop   <= bus.in_sop[r_grant];
                r_out_eop   <= bus.in_eop[r_grant];
                r_out_data  <= bus.in_data[int'(r_grant)*DWIDTH +: DWIDTH];
                r_out_empty <= bus.in_empty[int'(r_grant)*EWIDTH +: EWIDTH];
                r_out_port  <= r_grant;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.out_data  = r_out_data;
    assign bus.out_empty = r_out_empty;
    assign bus.out_port  = r_out_port;

`ifdef PKT_ARB_STATS_EN
    logic [NUM_PORTS-1:0][31:0] r_pkt_cnt;
    logic [15:0]                r_drop_cnt;
    logic [16:0]                w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'($countones(w_drop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int g = 0; g < NUM_PORTS; g++)
                if (w_acc_eop && (r_grant == PW'(g)))
                    r_pkt_cnt[g] <= r_pkt_cnt[g] + 32'd1;
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: doc/pkt_rr_arbiter.md
# pkt_rr_arbiter

Packet-granular round-robin arbiter that merges NUM_PORTS Avalon-ST packet streams (512-bit, sop/eop/empty) into one stream feeding the string_matcher input path. It sits in the clk domain, ahead of the in_pkt FIFO/CDC chain. A grant is held from sop to eop so packets are never interleaved. A single registered output stage provides ready/valid decoupling.

## Interface
- NUM_PORTS, 4, number of input streams (2..16)
- DWIDTH, 512, beat width in bits
- EWIDTH, 6, empty field width (bytes unused in eop beat)
- PW, $clog2(NUM_PORTS), port index width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_PORTS*DWIDTH  port g at [g*DWIDTH +: DWIDTH]
- in_valid  in  NUM_PORTS  per-port valid
- in_sop  in  NUM_PORTS  per-port start of packet
- in_eop  in  NUM_PORTS  per-port end of packet
- in_empty  in  NUM_PORTS*EWIDTH  port g at [g*EWIDTH +: EWIDTH]
- in_ready  out  NUM_PORTS  per-port ready
- out_data  out  DWIDTH  merged beat
- out_valid  out  1  output valid
- out_sop  out  1  start of packet
- out_eop  out  1  end of packet
- out_empty  out  EWIDTH  empty, meaningful only with out_eop
- out_port  out  PW  source port of current output beat
- out_ready  in  1  downstream ready
- pkt_cnt  out  NUM_PORTS*32  packets forwarded per port
- drop_cnt  out  16  orphan beats discarded

## Operation
- FSM: IDLE, LOCKED. Registers: grant[PW], rr_ptr[PW].
- IDLE: request r[g] = in_valid[g] & in_sop[g]. If any r, grant <= first g with r[g] searching rr_ptr, rr_ptr+1, ... mod NUM_PORTS; go LOCKED. No beat forwarded in IDLE.
- Orphan discard in IDLE: in_ready[g] = in_valid[g] & ~in_sop[g]; those beats are consumed and dropped. In LOCKED, in_ready of non-granted ports is 0.
- LOCKED: in_ready[grant] = ~out_valid | out_ready; beat accepted when in_valid[grant] & in_ready[grant]; loaded into output register with out_port = grant.
- Accepted beat with in_eop: go IDLE, rr_ptr <= (grant+1) mod NUM_PORTS. sop+eop on the same beat (single-beat packet) handled identically.
- in_sop on a non-first beat in LOCKED is forwarded unchanged; no framing repair.
- Output register: out_valid set on accept; cleared when out_ready & no new accept. out_* hold stable while out_valid & ~out_ready.
- Counters: pkt_cnt[g] +1 (wraps at 2^32) when an eop beat from g is accepted. drop_cnt += number of discarded beats that cycle, saturating at 0xFFFF.

## Timing
- Reset: out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, out_port=0, in_ready=0, state=IDLE, grant=0, rr_ptr=0, pkt_cnt=0, drop_cnt=0.
- Request to first output: sop visible in IDLE cycle 0 → grant registered at edge 1, in_ready high in cycle 1 → accepted at edge 2, out_valid in cycle 2.
- Steady state: one beat per cycle while out_ready=1; full throughput within a packet.
- Inter-packet gap: at least one IDLE cycle with no beat accepted after each eop.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready[grant]=0 the same cycle (combinational). No beat is lost or duplicated.
- Simultaneous requests: the lowest index at or after rr_ptr wins; others wait. No starvation: every requester is served within NUM_PORTS packets.
- Reset mid-packet: the packet is aborted, no eop is emitted, and all state returns to reset values on the next edge.

## Configuration
- PKT_ARB_STATS_EN defined: pkt_cnt and drop_cnt are implemented as above.
- Not defined: pkt_cnt and drop_cnt are tied to 0 and no counter registers are built. Orphan discard and arbitration are unchanged.

## Test plan
- Single port 0, 3-beat packet, empty=5 on eop, out_ready=1 → out_valid from cycle 2, 3 consecutive beats, out_sop on beat 0, out_eop+out_empty=5 on beat 2, out_port=0, pkt_cnt[0]=1.
- Ports 0..3 each hold a 2-beat packet from reset → output order ports 0,1,2,3; no interleave; 1 idle cycle between packets; every pkt_cnt[g]=1.
- Port 1 streams back-to-back packets, port 2 has one pending → order 1,2,1 (rr_ptr advances past 1).
- out_ready toggled 1,0,0,1 mid-packet → out_data held during stall; 4-beat packet emerges intact, in order.
- In IDLE, port 3 presents 2 beats with sop=0 → both consumed, nothing on output, drop_cnt=2 (0 without PKT_ARB_STATS_EN).
- rst asserted after beat 1 of 4 → next cycle out_valid=0, state IDLE, counters 0; a fresh sop is then granted normally.
